// File: rtl/note_hit_scorer_pkg.sv
// note_hit_scorer_pkg
// Shared types and constants for the note hit scorer.
// Contents:
//   - note code width and the rest code
//   - streak step size and multiplier ceiling
//   - FSM state type
//   - calc_mult(): multiplier derived from a streak value
package note_hit_scorer_pkg;

    localparam int               NOTE_W      = 4;
    localparam logic [NOTE_W-1:0] NOTE_REST  = 4'h0;
    localparam int               STREAK_STEP = 8;
    localparam logic [2:0]       MULT_MAX    = 3'd4;

    typedef enum logic {
        ST_IDLE,
        ST_JUDGE
    } state_t;

    // Multiplier = min(1 + streak/STREAK_STEP, MULT_MAX).
    function automatic logic [2:0] calc_mult(input logic [7:0] streak);
        logic [7:0] steps;
        steps = streak / 8'(STREAK_STEP);
        if (steps >= 8'(MULT_MAX - 3'd1)) begin
            return MULT_MAX;
        end
        return 3'(steps) + 3'd1;
    endfunction

endpackage

// File: rtl/note_hit_scorer_hold_timer.sv
// note_hold_timer
// Saturating count of matching cycles within one beat window.
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   i_enable     counting allowed (judging); counter forced to 0 otherwise
//   i_match      this cycle's pitch matches the current note
//   i_clear      window boundary; counter restarts after this cycle
//   o_hold_ok    count including this cycle's match is >= HOLD_MIN
module note_hold_timer #(
    parameter int HOLD_MIN = 4000000,
    parameter int CNT_W    = 26
) (
    input  logic clk,
    input  logic reset,
    input  logic i_enable,
    input  logic i_match,
    input  logic i_clear,
    output logic o_hold_ok
);

    localparam logic [CNT_W-1:0] HOLD_MIN_C = CNT_W'(HOLD_MIN);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_inc;

    always_comb begin
        w_count_inc = r_count;
        if (i_enable && i_match && (r_count != '1)) begin
            w_count_inc = r_count + CNT_W'(1);
        end
    end

    // Judged on the incremented value so the advance cycle's match counts.
    assign o_hold_ok = (w_count_inc >= HOLD_MIN_C);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (!i_enable || i_clear) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_inc;
        end
    end

endmodule

// File: rtl/note_hit_scorer.sv
// note_hit_scorer
// Judges each beat window as hit or miss against the loader's current
// note and keeps score, streak, multiplier and hit/miss tallies.
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   note_advance    beat pulse, same edge the loader shifts its notes
//   current_note    loader slot 0 note code (0 = rest)
//   detected_note   pitch detector note code
//   detected_valid  detected_note is meaningful this cycle
//   active          set by the first note_advance after reset
//   hit, miss       one-cycle judgement pulses, cycle after note_advance
//   score           saturating accumulated score
//   streak          consecutive hits, saturating at 255
//   multiplier      min(1 + streak/8, 4)
//   hit_count       total hits, saturating at 1023
//   miss_count      total misses, saturating at 1023
module note_hit_scorer
    import note_hit_scorer_pkg::*;
#(
    parameter int HOLD_MIN    = 4000000,
    parameter int BASE_POINTS = 10,
    parameter int SCORE_W     = 20,
    parameter int CNT_W       = 26
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               note_advance,
    input  logic [NOTE_W-1:0]  current_note,
    input  logic [NOTE_W-1:0]  detected_note,
    input  logic               detected_valid,
    output logic               active,
    output logic               hit,
    output logic               miss,
    output logic [SCORE_W-1:0] score,
    output logic [7:0]         streak,
    output logic [2:0]         multiplier,
    output logic [9:0]         hit_count,
    output logic [9:0]         miss_count
);

    localparam int               SUM_W     = SCORE_W + 8;
    localparam logic [SUM_W-1:0] SCORE_MAX = SUM_W'({SCORE_W{1'b1}});

    state_t             r_state;
    state_t             w_state_next;
    logic               r_active;
    logic               r_hit;
    logic               r_miss;
    logic [SCORE_W-1:0] r_score;
    logic [7:0]         r_streak;
    logic [2:0]         r_mult;
    logic [9:0]         r_hit_count;
    logic [9:0]         r_miss_count;

    logic               w_match;
    logic               w_eval;
    logic               w_hold_ok;
    logic               w_is_hit;
    logic               w_is_miss;
    logic [SUM_W-1:0]   w_score_sum;
    logic [SCORE_W-1:0] w_score_next;
    logic [7:0]         w_streak_next;

    assign w_match = detected_valid && (detected_note == current_note)
                     && (current_note != NOTE_REST);

    note_hold_timer #(
        .HOLD_MIN (HOLD_MIN),
        .CNT_W    (CNT_W)
    ) u_hold_timer (
        .clk       (clk),
        .reset     (reset),
        .i_enable  (r_state == ST_JUDGE),
        .i_match   (w_match),
        .i_clear   (note_advance),
        .o_hold_ok (w_hold_ok)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_eval       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (note_advance) begin
                    w_state_next = ST_JUDGE;
                end
            end
            ST_JUDGE: begin
                w_eval = note_advance;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // current_note still carries the closing window's note on the advance cycle.
    assign w_is_hit  = w_eval && (current_note != NOTE_REST) && w_hold_ok;
    assign w_is_miss = w_eval && (current_note != NOTE_REST) && !w_hold_ok;

    // r_mult always equals calc_mult(r_streak), i.e. the pre-hit multiplier.
    assign w_score_sum = SUM_W'(r_score) + SUM_W'(BASE_POINTS) * SUM_W'(r_mult);

    always_comb begin
        w_score_next  = r_score;
        w_streak_next = r_streak;
        if (w_is_hit) begin
            w_score_next = (w_score_sum > SCORE_MAX) ? {SCORE_W{1'b1}}
                                                     : SCORE_W'(w_score_sum);
            if (r_streak != 8'hFF) begin
                w_streak_next = r_streak + 8'd1;
            end
        end else if (w_is_miss) begin
            w_streak_next = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_active     <= 1'b0;
            r_hit        <= 1'b0;
            r_miss       <= 1'b0;
            r_score      <= '0;
            r_streak     <= '0;
            r_mult       <= 3'd1;
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if ((r_state == ST_IDLE) && note_advance) begin
                r_active <= 1'b1;
            end
            r_hit    <= w_is_hit;
            r_miss   <= w_is_miss;
            r_score  <= w_score_next;
            r_streak <= w_streak_next;
            r_mult   <= calc_mult(w_streak_next);
            if (w_is_hit && (r_hit_count != '1)) begin
                r_hit_count <= r_hit_count + 10'd1;
            end
            if (w_is_miss && (r_miss_count != '1)) begin
                r_miss_count <= r_miss_count + 10'd1;
            end
        end
    end

    assign active     = r_active;
    assign hit        = r_hit;
    assign miss       = r_miss;
    assign score      = r_score;
    assign streak     = r_streak;
    assign multiplier = r_mult;
    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;

endmodule

// File: tb/tb_note_hit_scorer.sv
module tb_note_hit_scorer;

    logic       clk = 1'b0;
    logic       reset;
    logic       note_advance;
    logic [3:0] current_note;
    logic [3:0] detected_note;
    logic       detected_valid;

    logic        active, hit, miss;
    logic [19:0] score;
    logic [7:0]  streak;
    logic [2:0]  multiplier;
    logic [9:0]  hit_count, miss_count;

    logic        active8, hit8, miss8;
    logic [7:0]  score8;
    logic [7:0]  streak8;
    logic [2:0]  multiplier8;
    logic [9:0]  hit_count8, miss_count8;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    note_hit_scorer #(
        .HOLD_MIN    (4),
        .BASE_POINTS (10),
        .SCORE_W     (20),
        .CNT_W       (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .note_advance   (note_advance),
        .current_note   (current_note),
        .detected_note  (detected_note),
        .detected_valid (detected_valid),
        .active         (active),
        .hit            (hit),
        .miss           (miss),
        .score          (score),
        .streak         (streak),
        .multiplier     (multiplier),
        .hit_count      (hit_count),
        .miss_count     (miss_count)
    );

    note_hit_scorer #(
        .HOLD_MIN    (4),
        .BASE_POINTS (10),
        .SCORE_W     (8),
        .CNT_W       (4)
    ) dut8 (
        .clk            (clk),
        .reset          (reset),
        .note_advance   (note_advance),
        .current_note   (current_note),
        .detected_note  (detected_note),
        .detected_valid (detected_valid),
        .active         (active8),
        .hit            (hit8),
        .miss           (miss8),
        .score          (score8),
        .streak         (streak8),
        .multiplier     (multiplier8),
        .hit_count      (hit_count8),
        .miss_count     (miss_count8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One beat window: len cycles (first n_match matching), then the advance cycle.
    task automatic run_window(input logic [3:0] note, input int n_match, input int len,
                              input logic valid, input logic match_on_adv);
        for (int i = 0; i < len; i++) begin
            current_note   = note;
            detected_note  = (i < n_match) ? note : ~note;
            detected_valid = valid;
            tick();
        end
        current_note   = note;
        detected_note  = match_on_adv ? note : ~note;
        detected_valid = valid;
        note_advance   = 1'b1;
        tick();
        note_advance   = 1'b0;
        detected_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        // first advance only leaves IDLE
        current_note = 4'd5; detected_note = 4'd5; detected_valid = 1'b1;
        note_advance = 1'b1;
        tick();
        note_advance = 1'b0; detected_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            current_note   = 4'($urandom_range(0, 15));
            detected_note  = 4'($urandom_range(0, 15));
            detected_valid = 1'($urandom_range(0, 1));
            note_advance   = (i == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            tick();
        end
        n_tests++; if (active !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %0b exp 0", active); end
        n_tests++; if (hit !== 1'b0 || miss !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: hit %0b miss %0b exp 0 0", hit, miss); end
        n_tests++; if (score !== 20'd0) begin n_fail++; $display("FAIL reset_score: got %0d exp 0", score); end
        n_tests++; if (streak !== 8'd0) begin n_fail++; $display("FAIL reset_streak: got %0d exp 0", streak); end
        n_tests++; if (multiplier !== 3'd1) begin n_fail++; $display("FAIL reset_mult: got %0d exp 1", multiplier); end
        n_tests++; if (hit_count !== 10'd0 || miss_count !== 10'd0) begin n_fail++; $display("FAIL reset_counts: got %0d/%0d exp 0/0", hit_count, miss_count); end
        reset = 1'b0; note_advance = 1'b0; detected_valid = 1'b0;
        tick();
        n_tests++; if (active !== 1'b0) begin n_fail++; $display("FAIL reset_adv_ignored: active got %0b exp 0", active); end
    endtask

    task automatic test_first_advance();
        current_note = 4'd5; detected_note = 4'd5; detected_valid = 1'b1;
        note_advance = 1'b1;
        tick();
        note_advance = 1'b0; detected_valid = 1'b0;
        n_tests++; if (active !== 1'b1) begin n_fail++; $display("FAIL first_adv_active: got %0b exp 1", active); end
        n_tests++; if (hit !== 1'b0 || miss !== 1'b0) begin n_fail++; $display("FAIL first_adv_no_pulse: hit %0b miss %0b exp 0 0", hit, miss); end
    endtask

    task automatic test_hit();
        run_window(4'd5, 6, 10, 1'b1, 1'b0);
        n_tests++; if (hit !== 1'b1 || miss !== 1'b0) begin n_fail++; $display("FAIL hit_pulse: hit %0b miss %0b exp 1 0", hit, miss); end
        n_tests++; if (score !== 20'd10) begin n_fail++; $display("FAIL hit_score: got %0d exp 10", score); end
        n_tests++; if (streak !== 8'd1 || multiplier !== 3'd1) begin n_fail++; $display("FAIL hit_streak_mult: got %0d/%0d exp 1/1", streak, multiplier); end
        n_tests++; if (hit_count !== 10'd1) begin n_fail++; $display("FAIL hit_count: got %0d exp 1", hit_count); end
        tick();
        n_tests++; if (hit !== 1'b0) begin n_fail++; $display("FAIL hit_one_cycle: got %0b exp 0", hit); end
    endtask

    task automatic test_miss();
        run_window(4'd5, 3, 10, 1'b1, 1'b0);
        n_tests++; if (miss !== 1'b1 || hit !== 1'b0) begin n_fail++; $display("FAIL miss_pulse: hit %0b miss %0b exp 0 1", hit, miss); end
        n_tests++; if (streak !== 8'd0 || score !== 20'd10) begin n_fail++; $display("FAIL miss_state: streak %0d score %0d exp 0 10", streak, score); end
        n_tests++; if (miss_count !== 10'd1) begin n_fail++; $display("FAIL miss_count: got %0d exp 1", miss_count); end
        run_window(4'd7, 10, 10, 1'b0, 1'b1);
        n_tests++; if (miss !== 1'b1) begin n_fail++; $display("FAIL miss_invalid: got %0b exp 1", miss); end
        n_tests++; if (miss_count !== 10'd2 || hit_count !== 10'd1) begin n_fail++; $display("FAIL miss_invalid_counts: got %0d/%0d exp 1/2", hit_count, miss_count); end
    endtask

    task automatic test_boundary();
        // 3 matches plus one on the advance cycle reaches HOLD_MIN exactly
        run_window(4'd9, 3, 6, 1'b1, 1'b1);
        n_tests++; if (hit !== 1'b1) begin n_fail++; $display("FAIL bound_adv_match: hit got %0b exp 1", hit); end
        n_tests++; if (score !== 20'd20 || streak !== 8'd1) begin n_fail++; $display("FAIL bound_adv_state: score %0d streak %0d exp 20 1", score, streak); end
        // 19 matches would wrap a 4-bit counter to 3; saturation keeps it at 15
        run_window(4'd3, 19, 19, 1'b1, 1'b0);
        n_tests++; if (hit !== 1'b1 || miss !== 1'b0) begin n_fail++; $display("FAIL bound_sat_cnt: hit %0b miss %0b exp 1 0", hit, miss); end
        n_tests++; if (score !== 20'd30 || hit_count !== 10'd3) begin n_fail++; $display("FAIL bound_sat_state: score %0d hits %0d exp 30 3", score, hit_count); end
    endtask

    task automatic test_rest();
        run_window(4'd0, 10, 10, 1'b1, 1'b1);
        n_tests++; if (hit !== 1'b0 || miss !== 1'b0) begin n_fail++; $display("FAIL rest_no_pulse: hit %0b miss %0b exp 0 0", hit, miss); end
        n_tests++; if (score !== 20'd30 || streak !== 8'd2) begin n_fail++; $display("FAIL rest_state: score %0d streak %0d exp 30 2", score, streak); end
        n_tests++; if (hit_count !== 10'd3 || miss_count !== 10'd2) begin n_fail++; $display("FAIL rest_counts: got %0d/%0d exp 3/2", hit_count, miss_count); end
    endtask

    task automatic test_streak_and_saturation();
        do_reset();
        for (int k = 1; k <= 33; k++) begin
            run_window(4'd5, 5, 5, 1'b1, 1'b0);
            if (k == 8) begin
                n_tests++; if (score !== 20'd80 || multiplier !== 3'd2) begin n_fail++; $display("FAIL streak8: score %0d mult %0d exp 80 2", score, multiplier); end
            end
            if (k == 16) begin
                n_tests++; if (score8 !== 8'd240) begin n_fail++; $display("FAIL sat_pre: score8 got %0d exp 240", score8); end
            end
            if (k == 17) begin
                n_tests++; if (score8 !== 8'd255) begin n_fail++; $display("FAIL sat_clip: score8 got %0d exp 255", score8); end
                n_tests++; if (score !== 20'd270) begin n_fail++; $display("FAIL streak17: score got %0d exp 270", score); end
            end
        end
        n_tests++; if (score !== 20'd840) begin n_fail++; $display("FAIL streak33_score: got %0d exp 840", score); end
        n_tests++; if (streak !== 8'd33 || multiplier !== 3'd4) begin n_fail++; $display("FAIL streak33_mult: streak %0d mult %0d exp 33 4", streak, multiplier); end
        n_tests++; if (hit_count !== 10'd33) begin n_fail++; $display("FAIL streak33_hits: got %0d exp 33", hit_count); end
        n_tests++; if (score8 !== 8'd255) begin n_fail++; $display("FAIL sat_hold: score8 got %0d exp 255", score8); end
        run_window(4'd5, 1, 5, 1'b1, 1'b0);
        n_tests++; if (streak !== 8'd0 || score !== 20'd840 || multiplier !== 3'd1) begin n_fail++; $display("FAIL break_miss: streak %0d score %0d mult %0d exp 0 840 1", streak, score, multiplier); end
        run_window(4'd5, 5, 5, 1'b1, 1'b0);
        n_tests++; if (streak !== 8'd1 || score !== 20'd850) begin n_fail++; $display("FAIL break_hit: streak %0d score %0d exp 1 850", streak, score); end
        n_tests++; if (score8 !== 8'd255) begin n_fail++; $display("FAIL sat_after: score8 got %0d exp 255", score8); end
    endtask

    task automatic test_reset_mid_window();
        for (int i = 0; i < 5; i++) begin
            current_note = 4'd5; detected_note = (i < 3) ? 4'd5 : 4'd2; detected_valid = 1'b1;
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_tests++; if (hit !== 1'b0 || miss !== 1'b0 || active !== 1'b0) begin n_fail++; $display("FAIL midreset: hit %0b miss %0b active %0b exp 0 0 0", hit, miss, active); end
        n_tests++; if (score !== 20'd0 || streak !== 8'd0) begin n_fail++; $display("FAIL midreset_state: score %0d streak %0d exp 0 0", score, streak); end
        current_note = 4'd5; detected_note = 4'd5; detected_valid = 1'b1;
        note_advance = 1'b1;
        tick();
        note_advance = 1'b0; detected_valid = 1'b0;
        n_tests++; if (hit !== 1'b0 || miss !== 1'b0 || active !== 1'b1) begin n_fail++; $display("FAIL midreset_idle_adv: hit %0b miss %0b active %0b exp 0 0 1", hit, miss, active); end
        n_tests++; if (hit_count !== 10'd0 || miss_count !== 10'd0) begin n_fail++; $display("FAIL midreset_counts: got %0d/%0d exp 0/0", hit_count, miss_count); end
    endtask

    initial begin
        reset = 1'b1; note_advance = 1'b0; current_note = '0;
        detected_note = '0; detected_valid = 1'b0;
        test_reset();
        test_first_advance();
        test_hit();
        test_miss();
        test_boundary();
        test_rest();
        test_streak_and_saturation();
        test_reset_mid_window();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
